lcd_seq: RTL and testbench

Command sequencer that sits directly upstream of the DE2 HD44780 byte writer. After reset it runs the LCD power-up/initialisation command list, then accepts character-write requests (character + screen position) over a valid/ready handshake. Each request becomes a DDRAM set-address command followed by a data write, issued one byte at a time to the byte writer via a start/done handshake, with the controller-mandated execution delays enforced between bytes.

---
 rtl/lcd_seq.sv | 125 ++++++++++++
 tb/tb_lcd_seq.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/lcd_seq.sv
// lcd_seq: HD44780 power-up/init and character-write command sequencer feeding a byte writer.
// Optional feature macro LCD_SEQ_CURSOR_OPT_EN: skip the set-address byte when the request
// position matches the tracked cursor.
module lcd_seq #(
   parameter int CMD_WAIT_CYC   = 2000,
   parameter int CLR_WAIT_CYC   = 82000,
   parameter int PWRUP_WAIT_CYC = 750000,
   parameter int CNT_W          = 20
) (
   input  logic       iClk,
   input  logic       nRst,
   input  logic       iReqValid,
   output logic       oReqReady,
   input  logic [7:0] iReqChar,
   input  logic [4:0] iReqPos,
   output logic       oInitDone,
   output logic       oStart,
   output logic [7:0] oData,
   output logic       oRS,
   input  logic       iDone
);
   typedef enum logic [2:0] {PWRUP, ISSUE, WAIT, DELAY, IDLE} state_t;
   typedef enum logic [2:0] {INIT0, INIT1, INIT2, INIT3, INIT4, ADDR, CHAR} phase_t;

   state_t           state, state_n;
   phase_t           phase, phase_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [7:0]       chr, byte_n;
   logic             accept, fin, hit;

   assign accept = state == IDLE && iReqValid && oReqReady;
   assign fin    = state == DELAY && cnt == '0;
   assign byte_n = phase_n == ADDR  ? {1'b1, iReqPos[4], 2'b00, iReqPos[3:0]} :
                   phase_n == CHAR  ? (accept ? iReqChar : chr) :
                   phase_n == INIT2 ? 8'h0C :
                   phase_n == INIT3 ? 8'h01 :
                   phase_n == INIT4 ? 8'h06 : 8'h38;

`ifdef LCD_SEQ_CURSOR_OPT_EN
   logic [4:0] pos, cur_pos;
   logic       cur_vld;
   assign hit = cur_vld && iReqPos == cur_pos;
   // Cursor tracking: home after init, advance after each character, lost past column 15
   always_ff @(posedge iClk or negedge nRst)
      if (!nRst) begin
         pos     <= '0;
         cur_pos <= '0;
         cur_vld <= 1'b0;
      end else begin
         if (accept) pos <= iReqPos;
         if (fin && phase == INIT4) begin
            cur_pos <= '0;
            cur_vld <= 1'b1;
         end
         if (fin && phase == CHAR) begin
            cur_pos <= pos + 5'd1;
            cur_vld <= pos[3:0] != 4'hF;
         end
      end
`else
   assign hit = 1'b0;
`endif

   // Next-state, next-phase and delay counter logic
   always_comb begin
      state_n = state;
      phase_n = phase;
      cnt_n   = cnt;
      case (state)
         PWRUP:
            if (cnt == CNT_W'(PWRUP_WAIT_CYC - 1)) begin
               state_n = ISSUE;
               phase_n = INIT0;
            end else
               cnt_n = cnt + CNT_W'(1);
         ISSUE: state_n = WAIT;
         WAIT:
            if (iDone) begin
               state_n = DELAY;
               cnt_n   = (oData == 8'h01 && !oRS) ? CNT_W'(CLR_WAIT_CYC - 1) : CNT_W'(CMD_WAIT_CYC - 1);
            end
         DELAY:
            if (cnt != '0)
               cnt_n = cnt - CNT_W'(1);
            else if (phase == INIT4 || phase == CHAR)
               state_n = IDLE;
            else begin
               state_n = ISSUE;
               phase_n = phase == ADDR ? CHAR : phase_t'(phase + 3'd1);
            end
         IDLE:
            if (accept) begin
               state_n = ISSUE;
               phase_n = hit ? CHAR : ADDR;
            end
         default: state_n = PWRUP;
      endcase
   end

   // State register and registered outputs derived from the upcoming state
   always_ff @(posedge iClk or negedge nRst)
      if (!nRst) begin
         state     <= PWRUP;
         phase     <= INIT0;
         cnt       <= '0;
         chr       <= '0;
         oStart    <= 1'b0;
         oData     <= '0;
         oRS       <= 1'b0;
         oReqReady <= 1'b0;
         oInitDone <= 1'b0;
      end else begin
         state     <= state_n;
         phase     <= phase_n;
         cnt       <= cnt_n;
         oStart    <= state_n == ISSUE;
         oReqReady <= state_n == IDLE;
         if (accept) chr <= iReqChar;
         if (state_n == ISSUE) begin
            oData <= byte_n;
            oRS   <= phase_n == CHAR;
         end
         if (fin && phase == INIT4) oInitDone <= 1'b1;
      end
endmodule

// File: tb/tb_lcd_seq.sv
// tb_lcd_seq: directed table-driven bench for lcd_seq with a 3-cycle byte-writer model
`timescale 1ns/1ps
module tb_lcd_seq;
   localparam int PW = 10, CMD = 4, CLR = 8, BW = 3;
   localparam int STEP = 1 + BW + CMD;

   logic       iClk = 0, nRst = 0, iReqValid = 0, bw_done = 0, spur_done = 0, iDone;
   logic [7:0] iReqChar = 0;
   logic [4:0] iReqPos = 0;
   logic       oReqReady, oInitDone, oStart, oRS;
   logic [7:0] oData;
   int         cyc = 0, errors = 0, checks = 0;

   typedef struct {logic [7:0] d; logic rs; int c;} ev_t;
   typedef struct {logic [7:0] ch; logic [4:0] pos; int n; logic [7:0] b0; logic [7:0] b1;} vec_t;
   ev_t  log_q[$];
   vec_t tbl[10];
   logic [7:0] init_b[5];

   assign iDone = bw_done | spur_done;

   lcd_seq #(.CMD_WAIT_CYC(CMD), .CLR_WAIT_CYC(CLR), .PWRUP_WAIT_CYC(PW), .CNT_W(20)) dut (
      .iClk(iClk), .nRst(nRst), .iReqValid(iReqValid), .oReqReady(oReqReady),
      .iReqChar(iReqChar), .iReqPos(iReqPos), .oInitDone(oInitDone), .oStart(oStart),
      .oData(oData), .oRS(oRS), .iDone(iDone));

   always #5 iClk = ~iClk;
   always @(posedge iClk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Byte log: every start pulse with its byte and cycle
   initial begin
      ev_t e;
      forever begin
         @(negedge iClk);
         if (oStart) begin
            e.d = oData; e.rs = oRS; e.c = cyc;
            log_q.push_back(e);
         end
      end
   end

   // Byte writer model: done pulse 3 cycles after start
   initial forever begin
      @(negedge iClk);
      if (oStart) begin
         repeat (BW) @(posedge iClk);
         #1 bw_done = 1;
         @(posedge iClk);
         #1 bw_done = 0;
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic run_init();
      int t = 0, x;
      bit early = 0;
      log_q.delete();
      @(negedge iClk) nRst = 1;
      x = cyc;
      while (!oReqReady && t < 400) begin
         if (oInitDone) early = 1;
         @(negedge iClk);
         t++;
      end
      chk("init_timeout", t < 400, 1);
      chk("initdone_early", early, 0);
      chk("initdone", oInitDone, 1);
      chk("init_count", log_q.size(), 5);
      if (log_q.size() > 0) chk("pwrup_delay", log_q[0].c - x, PW);
      for (int i = 0; i < 5 && i < log_q.size(); i++) begin
         chk($sformatf("init%0d_data", i), log_q[i].d, init_b[i]);
         chk($sformatf("init%0d_rs", i), log_q[i].rs, 0);
         if (i > 0) chk($sformatf("init%0d_gap", i), log_q[i].c - log_q[i-1].c, i == 4 ? 1 + BW + CLR : STEP);
      end
      if (log_q.size() == 5) chk("init_ready_lat", cyc - log_q[4].c, STEP);
   endtask

   task automatic do_req(input logic [7:0] ch, input logic [4:0] p, input int n,
                         input logic [7:0] b0, input logic [7:0] b1, input int spur_at);
      int t = 0, a;
      log_q.delete();
      iReqValid = 1; iReqChar = ch; iReqPos = p;
      while (!oReqReady && t < 200) begin @(negedge iClk); t++; end
      @(negedge iClk);
      iReqValid = 0;
      chk($sformatf("req%0h_start", ch), oStart, 1);
      chk($sformatf("req%0h_ready_low", ch), oReqReady, 0);
      chk($sformatf("req%0h_first", ch), oData, b0);
      a = cyc;
      t = 0;
      while (!oReqReady && t < 200) begin
         @(negedge iClk);
         t++;
         spur_done = spur_at >= 0 && cyc == a + spur_at;
      end
      spur_done = 0;
      chk($sformatf("req%0h_timeout", ch), t < 200, 1);
      chk($sformatf("req%0h_count", ch), log_q.size(), n);
      if (log_q.size() > 0) begin
         chk($sformatf("req%0h_b0", ch), log_q[0].d, b0);
         chk($sformatf("req%0h_rs0", ch), log_q[0].rs, n == 1);
      end
      if (n == 2 && log_q.size() > 1) begin
         chk($sformatf("req%0h_b1", ch), log_q[1].d, b1);
         chk($sformatf("req%0h_rs1", ch), log_q[1].rs, 1);
      end
      chk($sformatf("req%0h_lat", ch), cyc - a, n * STEP);
   endtask

   initial begin
      int t;
      init_b = '{8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
      tbl[0] = '{8'h41, 5'h00, 2, 8'h80, 8'h41};
      tbl[1] = '{8'h42, 5'h13, 2, 8'hC3, 8'h42};
      tbl[3] = '{8'h44, 5'h01, 2, 8'h81, 8'h44};
      tbl[5] = '{8'h46, 5'h0F, 2, 8'h8F, 8'h46};
      tbl[6] = '{8'h47, 5'h10, 2, 8'hC0, 8'h47};
      tbl[8] = '{8'h49, 5'h1F, 2, 8'hCF, 8'h49};
      tbl[9] = '{8'h4C, 5'h00, 2, 8'h80, 8'h4C};
`ifdef LCD_SEQ_CURSOR_OPT_EN
      tbl[2] = '{8'h43, 5'h14, 1, 8'h43, 8'h00};
      tbl[4] = '{8'h45, 5'h02, 1, 8'h45, 8'h00};
      tbl[7] = '{8'h48, 5'h11, 1, 8'h48, 8'h00};
`else
      tbl[2] = '{8'h43, 5'h14, 2, 8'hC4, 8'h43};
      tbl[4] = '{8'h45, 5'h02, 2, 8'h82, 8'h45};
      tbl[7] = '{8'h48, 5'h11, 2, 8'hC1, 8'h48};
`endif
      iReqValid = 1; iReqChar = 8'h5A; iReqPos = 5'h05;
      repeat (2) @(negedge iClk);
      #1;
      chk("rst_start", oStart, 0);
      chk("rst_ready", oReqReady, 0);
      chk("rst_initdone", oInitDone, 0);
      chk("rst_data", oData, 0);
      chk("rst_rs", oRS, 0);
      run_init();
      do_req(8'h5A, 5'h05, 2, 8'h85, 8'h5A, -1);
      for (int i = 0; i < 10; i++) do_req(tbl[i].ch, tbl[i].pos, tbl[i].n, tbl[i].b0, tbl[i].b1, -1);
      // Spurious done while idle
      log_q.delete();
      spur_done = 1;
      @(negedge iClk) spur_done = 0;
      @(negedge iClk);
      chk("spur_idle_ready", oReqReady, 1);
      chk("spur_idle_start", oStart, 0);
      chk("spur_idle_log", log_q.size(), 0);
      // Spurious done during the first DELAY cycles of the address byte
      do_req(8'h4B, 5'h05, 2, 8'h85, 8'h4B, 5);
      // Reset while WAIT holds the character byte
      log_q.delete();
      iReqValid = 1; iReqChar = 8'h4A; iReqPos = 5'h0A;
      @(negedge iClk);
      iReqValid = 0;
      t = 0;
      while (log_q.size() < 2 && t < 100) begin @(negedge iClk); #1; t++; end
      chk("rstw_timeout", t < 100, 1);
      @(negedge iClk);
      chk("rstw_data", oData, 8'h4A);
      chk("rstw_rs", oRS, 1);
      chk("rstw_start", oStart, 0);
      #2 nRst = 0;
      #1;
      chk("rstw_start0", oStart, 0);
      chk("rstw_data0", oData, 0);
      chk("rstw_rs0", oRS, 0);
      chk("rstw_ready0", oReqReady, 0);
      chk("rstw_initdone0", oInitDone, 0);
      repeat (3) @(negedge iClk);
      run_init();
`ifdef LCD_SEQ_CURSOR_OPT_EN
      do_req(8'h4D, 5'h00, 1, 8'h4D, 8'h00, -1);
`else
      do_req(8'h4D, 5'h00, 2, 8'h80, 8'h4D, -1);
`endif
      repeat (3) @(negedge iClk);
      chk("final_ready", oReqReady, 1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
